// File: rtl/sw_key_capture_slave.sv
// Avalon-MM slave: synchronises SW, debounces the active-low load key
// and latches SW on each debounced press, with status flags and irq.
module sw_key_capture_slave #(
    parameter int SW_WIDTH        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw_in,
    input  logic                key_n,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_sync;
    logic                key_s1;
    logic                key_sync;
    logic                key_db;
    logic                key_db_q;
    logic [CNT_W-1:0]    cnt;
    logic [SW_WIDTH-1:0] data_q;
    logic                new_q;
    logic                ovr_q;
    logic                irq_en_q;
    logic                press;
    logic                wr_status;
    logic                wr_control;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign unused_wdata = ^avs_writedata[31:2];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_s1    <= '0;
            sw_sync  <= '0;
            key_s1   <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            sw_s1    <= sw_in;
            sw_sync  <= sw_s1;
            key_s1   <= key_n;
            key_sync <= key_s1;
        end
    end

    // Any return to equality before the count expires restarts qualification
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt      <= '0;
            key_db   <= 1'b1;
            key_db_q <= 1'b1;
        end else begin
            key_db_q <= key_db;
            if (key_sync == key_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_db <= key_sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press      = key_db_q & ~key_db;
    assign wr_status  = avs_write && (avs_address == 2'd2);
    assign wr_control = avs_write && (avs_address == 2'd3);

    // A capture takes priority over a simultaneous write-1-to-clear
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            data_q   <= '0;
            new_q    <= 1'b0;
            ovr_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (press) begin
                data_q <= sw_sync;
            end
            if (press) begin
                new_q <= 1'b1;
            end else if (wr_status && avs_writedata[0]) begin
                new_q <= 1'b0;
            end
            if (press && new_q) begin
                ovr_q <= 1'b1;
            end else if (wr_status && avs_writedata[1]) begin
                ovr_q <= 1'b0;
            end
            if (wr_control) begin
                irq_en_q <= avs_writedata[0];
            end
            irq <= new_q & irq_en_q;
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0: rd_mux = {{(32-SW_WIDTH){1'b0}}, data_q};
            2'd1: rd_mux = {{(32-SW_WIDTH){1'b0}}, sw_sync};
            2'd2: rd_mux = {30'b0, ovr_q, new_q};
            2'd3: rd_mux = {31'b0, irq_en_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sw_key_capture_slave.sv
// Randomised key/switch stimulus checked against a press-level model
// of capture, status flags and interrupt.
module tb_sw_key_capture_slave;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw_in;
    logic        key_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    sw_key_capture_slave #(
        .SW_WIDTH(4),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .sw_in(sw_in),
        .key_n(key_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a,
                              input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Edges from now until irq is seen high, capped at 40
    task automatic wait_irq(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irq && n < 40);
    endtask

    task automatic press(input logic [3:0] sw);
        sw_in = sw;
        key_n = 1'b0;
        tick(12);
        key_n = 1'b1;
        tick(12);
    endtask

    logic [3:0]  m_data;
    logic        m_new;
    logic        m_ovr;
    logic        m_en;
    logic        m_db;
    logic [3:0]  m_sw;
    logic [31:0] rd;
    logic        irq_ok;
    int          n;

    initial begin
        reset = 1'b1;
        sw_in = 4'h0;
        key_n = 1'b1;
        avs_address = 2'd0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        tick(3);
        reset = 1'b0;

        check("reset_irq", {31'b0, irq}, 0);
        check("reset_rdata", avs_readdata, 0);
        for (int a = 0; a < 4; a++)
            read_check($sformatf("reset_reg%0d", a), 2'(a), 0);

        sw_in = 4'hA;
        key_n = 1'b0;
        tick(10);
        read_check("t2_data", 2'd0, 32'hA);
        read_check("t2_status", 2'd2, 32'h1);
        key_n = 1'b1;
        tick(10);
        read_check("t2_status_rel", 2'd2, 32'h1);
        bus_write(2'd2, 32'h1);

        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0;
            tick(2);
            key_n = 1'b1;
            tick(2);
        end
        tick(10);
        read_check("t3_status", 2'd2, 32'h0);
        read_check("t3_data", 2'd0, 32'hA);

        press(4'h3);
        press(4'h5);
        read_check("t4_data", 2'd0, 32'h5);
        read_check("t4_status", 2'd2, 32'h3);
        bus_write(2'd2, 32'h2);
        read_check("t4_clr_ovr", 2'd2, 32'h1);
        bus_write(2'd2, 32'h1);
        read_check("t4_clr_new", 2'd2, 32'h0);

        bus_write(2'd3, 32'h1);
        tick(3);
        check("t5_irq_idle", {31'b0, irq}, 0);
        sw_in = 4'h9;
        key_n = 1'b0;
        wait_irq(n);
        check("t5_irq_latency", n, D + 4);
        tick(3);
        key_n = 1'b1;
        tick(12);
        sw_in = 4'hC;
        key_n = 1'b0;
        irq_ok = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            if (j == D + 3) begin
                avs_address   = 2'd2;
                avs_writedata = 32'h1;
                avs_write     = 1'b1;
            end
            @(negedge clk);
            avs_write = 1'b0;
            irq_ok = irq_ok & irq;
        end
        check("t5_irq_hold", {31'b0, irq_ok}, 1);
        read_check("t5_status", 2'd2, 32'h3);
        read_check("t5_data", 2'd0, 32'hC);

        avs_address   = 2'd3;
        avs_writedata = 32'h0;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        check("rw_same_addr", avs_readdata, 32'h1);
        read_check("rw_after", 2'd3, 32'h0);
        bus_write(2'd3, 32'h1);

        key_n = 1'b1;
        tick(12);
        sw_in = 4'h6;
        key_n = 1'b0;
        tick(4);
        reset = 1'b1;
        @(negedge clk);
        check("t6_irq_rst", {31'b0, irq}, 0);
        check("t6_rdata_rst", avs_readdata, 0);
        reset = 1'b0;
        avs_address   = 2'd3;
        avs_writedata = 32'h1;
        avs_write     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            avs_write = 1'b0;
            n++;
        end while (!irq && n < 40);
        check("t6_requalify", n, D + 4);
        read_check("t6_status", 2'd2, 32'h1);
        read_check("t6_data", 2'd0, 32'h6);

        key_n = 1'b1;
        tick(12);
        bus_write(2'd2, 32'h3);
        bus_write(2'd3, 32'h0);
        m_data = 4'h6;
        m_new  = 1'b0;
        m_ovr  = 1'b0;
        m_en   = 1'b0;
        m_db   = 1'b1;
        m_sw   = 4'h6;

        // Runs shorter than D never qualify; long runs of the other level flip the debounced key
        for (int s = 0; s < 60; s++) begin
            logic v;
            logic [1:0] w;
            v = s[0] ? 1'b1 : 1'b0;
            v = ~v;
            if ($urandom_range(0, 2) == 0) begin
                key_n = v;
                tick($urandom_range(1, D - 1));
            end else begin
                m_sw  = 4'($urandom_range(0, 15));
                sw_in = m_sw;
                key_n = v;
                tick($urandom_range(12, 20));
                if (v != m_db) begin
                    m_db = v;
                    if (!v) begin
                        if (m_new) m_ovr = 1'b1;
                        m_new  = 1'b1;
                        m_data = m_sw;
                    end
                end
                if ($urandom_range(0, 1) == 1) begin
                    w = 2'($urandom_range(0, 3));
                    bus_write(2'd2, {30'b0, w});
                    if (w[0]) m_new = 1'b0;
                    if (w[1]) m_ovr = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    m_en = 1'($urandom_range(0, 1));
                    bus_write(2'd3, {31'b0, m_en});
                end
                read_check("rnd_data", 2'd0, {28'b0, m_data});
                read_check("rnd_live", 2'd1, {28'b0, m_sw});
                read_check("rnd_status", 2'd2, {30'b0, m_ovr, m_new});
                read_check("rnd_ctrl", 2'd3, {31'b0, m_en});
                check("rnd_irq", {31'b0, irq}, {31'b0, m_new & m_en});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
